// File: rtl/lagarto_plic_gateway.sv
// Per-source PLIC interrupt gateway: synchronises raw lines, turns level/edge requests into
// pending bits, and holds each source off from claim until completion.
//
// state         | meaning
// ST_IDLE       | no request forwarded; waiting for level high or a counted edge
// ST_PENDING    | request presented to the core, awaiting claim
// ST_IN_SERVICE | claimed by a target, awaiting completion
module lagarto_plic_gateway #(
  parameter int NUM_SOURCES    = 2,
  parameter int MAX_EDGE_COUNT = 8,
  parameter int ID_WIDTH       = $clog2(NUM_SOURCES + 1),
  parameter int CNT_WIDTH      = $clog2(MAX_EDGE_COUNT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NUM_SOURCES-1:0] irq_src_i,
  input  logic [NUM_SOURCES-1:0] edge_sel_i,
  output logic [NUM_SOURCES-1:0] pending_o,
  input  logic                   claim_valid_i,
  input  logic [ID_WIDTH-1:0]    claim_id_i,
  input  logic                   complete_valid_i,
  input  logic [ID_WIDTH-1:0]    complete_id_i,
  output logic [NUM_SOURCES-1:0] in_service_o,
  output logic [NUM_SOURCES-1:0] overflow_o
);

  // Encoding chosen so each output is a single state flop bit.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_PENDING    = 2'b01,
    ST_IN_SERVICE = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_EDGE_COUNT);

  logic [NUM_SOURCES-1:0] r_sync1;
  logic [NUM_SOURCES-1:0] r_sync2;
  logic [NUM_SOURCES-1:0] r_hist;
  logic [NUM_SOURCES-1:0] r_overflow;
  state_t                 r_state [NUM_SOURCES];
  logic [CNT_WIDTH-1:0]   r_count [NUM_SOURCES];

  logic [NUM_SOURCES-1:0] w_edge;
  logic [NUM_SOURCES-1:0] w_req;
  logic [NUM_SOURCES-1:0] w_claim;
  logic [NUM_SOURCES-1:0] w_complete;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= irq_src_i;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  always_comb begin
    w_edge     = '0;
    w_req      = '0;
    w_claim    = '0;
    w_complete = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_edge[i]     = r_sync2[i] & ~r_hist[i] & edge_sel_i[i];
      w_req[i]      = edge_sel_i[i] ? (w_edge[i] | (r_count[i] != '0)) : r_sync2[i];
      w_claim[i]    = claim_valid_i && (claim_id_i == ID_WIDTH'(i + 1));
      w_complete[i] = complete_valid_i && (complete_id_i == ID_WIDTH'(i + 1));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_overflow <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        r_state[i] <= ST_IDLE;
        r_count[i] <= '0;
      end
    end else begin
      r_overflow <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        unique case (r_state[i])
          ST_IDLE:       if (w_req[i])      r_state[i] <= ST_PENDING;
          ST_PENDING:    if (w_claim[i])    r_state[i] <= ST_IN_SERVICE;
          ST_IN_SERVICE: if (w_complete[i]) r_state[i] <= ST_IDLE;
          default:                          r_state[i] <= ST_IDLE;
        endcase

        // An edge arriving on the IDLE->PENDING step is consumed by that request,
        // so a stored count only drops when no new edge replaces it.
        if (!edge_sel_i[i]) begin
          r_count[i] <= '0;
        end else if ((r_state[i] == ST_IDLE) && w_req[i]) begin
          if ((r_count[i] != '0) && !w_edge[i])
            r_count[i] <= r_count[i] - CNT_ONE;
        end else if (w_edge[i]) begin
          if (r_count[i] == CNT_MAX)
            r_overflow[i] <= 1'b1;
          else
            r_count[i] <= r_count[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    pending_o    = '0;
    in_service_o = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      pending_o[i]    = r_state[i][0];
      in_service_o[i] = r_state[i][1];
    end
  end

  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_lagarto_plic_gateway.sv
// Directed bench for lagarto_plic_gateway: level/edge requests, claim/complete handshake,
// counter saturation, ignored IDs and asynchronous reset.
module tb_lagarto_plic_gateway;

  localparam int NS  = 2;
  localparam int MAX = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NS-1:0] irq_src;
  logic [NS-1:0] edge_sel;
  logic [NS-1:0] pending;
  logic          claim_valid;
  logic [1:0]    claim_id;
  logic          complete_valid;
  logic [1:0]    complete_id;
  logic [NS-1:0] in_service;
  logic [NS-1:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_cnt   = 0;

  always #5 clk = ~clk;

  lagarto_plic_gateway #(.NUM_SOURCES(NS), .MAX_EDGE_COUNT(MAX)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .irq_src_i        (irq_src),
    .edge_sel_i       (edge_sel),
    .pending_o        (pending),
    .claim_valid_i    (claim_valid),
    .claim_id_i       (claim_id),
    .complete_valid_i (complete_valid),
    .complete_id_i    (complete_id),
    .in_service_o     (in_service),
    .overflow_o       (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (overflow[1]) ov_cnt++;
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    irq_src        = '0;
    edge_sel       = '0;
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic claim(input logic [1:0] id);
    claim_valid = 1'b1;
    claim_id    = id;
    tick();
    claim_valid = 1'b0;
  endtask

  task automatic complete(input logic [1:0] id);
    complete_valid = 1'b1;
    complete_id    = id;
    tick();
    complete_valid = 1'b0;
  endtask

  task automatic pulse1();
    irq_src[1] = 1'b1;
    tick();
    tick();
    irq_src[1] = 1'b0;
    tick();
    tick();
  endtask

  // Serve source 1 until it stops re-pending; returns the number of services.
  task automatic drain1(input int max_srv, output int services);
    bit got;
    services = 0;
    for (int k = 0; k < max_srv; k++) begin
      got = 1'b0;
      for (int t = 0; t < 5 && !got; t++) begin
        if (pending[1]) got = 1'b1;
        else tick();
      end
      if (!got) break;
      claim(2'd2);
      complete(2'd2);
      services++;
    end
  endtask

  task automatic test_reset();
    rstn           = 1'b0;
    irq_src        = '0;
    edge_sel       = '0;
    claim_valid    = 1'b0;
    claim_id       = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    tick();
    n_checks++;
    if (pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending got=%b exp=00", pending); end
    n_checks++;
    if (in_service !== 2'b00) begin n_fail++; $display("FAIL reset_in_service got=%b exp=00", in_service); end
    n_checks++;
    if (overflow !== 2'b00) begin n_fail++; $display("FAIL reset_overflow got=%b exp=00", overflow); end
  endtask

  task automatic test_level();
    do_reset();
    irq_src[0] = 1'b1;
    tick();
    n_checks++;
    if (pending !== 2'b00) begin n_fail++; $display("FAIL lvl_lat_edge1 got=%b exp=00", pending); end
    tick();
    n_checks++;
    if (pending !== 2'b00) begin n_fail++; $display("FAIL lvl_lat_edge2 got=%b exp=00", pending); end
    tick();
    n_checks++;
    if (pending !== 2'b01) begin n_fail++; $display("FAIL lvl_lat_edge3 got=%b exp=01", pending); end
    claim(2'd1);
    n_checks++;
    if (pending !== 2'b00) begin n_fail++; $display("FAIL lvl_claim_pending got=%b exp=00", pending); end
    n_checks++;
    if (in_service !== 2'b01) begin n_fail++; $display("FAIL lvl_claim_in_service got=%b exp=01", in_service); end
    irq_src[0] = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (in_service !== 2'b01) begin n_fail++; $display("FAIL lvl_hold_in_service got=%b exp=01", in_service); end
    complete(2'd1);
    n_checks++;
    if (in_service !== 2'b00) begin n_fail++; $display("FAIL lvl_complete_in_service got=%b exp=00", in_service); end
    repeat (4) tick();
    n_checks++;
    if (pending !== 2'b00) begin n_fail++; $display("FAIL lvl_stays_idle got=%b exp=00", pending); end
  endtask

  task automatic test_level_repend();
    do_reset();
    irq_src[0] = 1'b1;
    repeat (3) tick();
    claim(2'd1);
    complete(2'd1);
    n_checks++;
    if ({pending, in_service} !== 4'b0000) begin
      n_fail++; $display("FAIL repend_idle_gap pend/insvc got=%b exp=0000", {pending, in_service});
    end
    tick();
    n_checks++;
    if (pending !== 2'b01) begin n_fail++; $display("FAIL repend_pending got=%b exp=01", pending); end
  endtask

  task automatic test_edge_count();
    int services;
    do_reset();
    edge_sel = 2'b10;
    ov_cnt   = 0;
    repeat (3) pulse1();
    tick();
    tick();
    n_checks++;
    if (pending !== 2'b10) begin n_fail++; $display("FAIL edge_pending got=%b exp=10", pending); end
    drain1(6, services);
    n_checks++;
    if (services !== 3) begin n_fail++; $display("FAIL edge_services got=%0d exp=3", services); end
    repeat (4) tick();
    n_checks++;
    if (pending !== 2'b00) begin n_fail++; $display("FAIL edge_drained got=%b exp=00", pending); end
    n_checks++;
    if (ov_cnt !== 0) begin n_fail++; $display("FAIL edge_no_overflow got=%0d exp=0", ov_cnt); end
  endtask

  task automatic test_saturation();
    int services;
    do_reset();
    edge_sel = 2'b10;
    ov_cnt   = 0;
    repeat (MAX + 1) pulse1();
    repeat (3) tick();
    n_checks++;
    if (ov_cnt !== 0) begin n_fail++; $display("FAIL sat_early_overflow got=%0d exp=0", ov_cnt); end
    pulse1();
    repeat (3) tick();
    n_checks++;
    if (ov_cnt !== 1) begin n_fail++; $display("FAIL sat_overflow_pulses got=%0d exp=1", ov_cnt); end
    n_checks++;
    if (pending !== 2'b10) begin n_fail++; $display("FAIL sat_pending got=%b exp=10", pending); end
    // One service for the initial request plus one per saturated count.
    drain1(12, services);
    n_checks++;
    if (services !== MAX + 1) begin n_fail++; $display("FAIL sat_services got=%0d exp=%0d", services, MAX + 1); end
  endtask

  task automatic test_illegal_ids();
    do_reset();
    irq_src[0] = 1'b1;
    repeat (3) tick();
    claim(2'd0);
    n_checks++;
    if ({pending, in_service} !== 4'b0100) begin
      n_fail++; $display("FAIL ill_claim_id0 pend/insvc got=%b exp=0100", {pending, in_service});
    end
    claim(2'd3);
    n_checks++;
    if ({pending, in_service} !== 4'b0100) begin
      n_fail++; $display("FAIL ill_claim_id3 pend/insvc got=%b exp=0100", {pending, in_service});
    end
    claim(2'd2);
    n_checks++;
    if ({pending, in_service} !== 4'b0100) begin
      n_fail++; $display("FAIL ill_claim_idle_src pend/insvc got=%b exp=0100", {pending, in_service});
    end
    complete(2'd1);
    n_checks++;
    if ({pending, in_service} !== 4'b0100) begin
      n_fail++; $display("FAIL ill_complete_pending pend/insvc got=%b exp=0100", {pending, in_service});
    end
    claim(2'd1);
    complete(2'd2);
    n_checks++;
    if ({pending, in_service} !== 4'b0001) begin
      n_fail++; $display("FAIL ill_complete_other pend/insvc got=%b exp=0001", {pending, in_service});
    end
    complete(2'd3);
    n_checks++;
    if ({pending, in_service} !== 4'b0001) begin
      n_fail++; $display("FAIL ill_complete_id3 pend/insvc got=%b exp=0001", {pending, in_service});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    irq_src = 2'b11;
    repeat (3) tick();
    n_checks++;
    if (pending !== 2'b11) begin n_fail++; $display("FAIL b2b_both_pending got=%b exp=11", pending); end
    claim(2'd1);
    claim_valid    = 1'b1;
    claim_id       = 2'd2;
    complete_valid = 1'b1;
    complete_id    = 2'd1;
    tick();
    claim_valid    = 1'b0;
    complete_valid = 1'b0;
    n_checks++;
    if ({pending, in_service} !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_same_cycle pend/insvc got=%b exp=0010", {pending, in_service});
    end
    tick();
    n_checks++;
    if ({pending, in_service} !== 4'b0110) begin
      n_fail++; $display("FAIL b2b_src0_repend pend/insvc got=%b exp=0110", {pending, in_service});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    edge_sel = 2'b10;
    repeat (3) pulse1();
    tick();
    tick();
    claim(2'd2);
    n_checks++;
    if (in_service !== 2'b10) begin n_fail++; $display("FAIL arst_setup in_service got=%b exp=10", in_service); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({pending, in_service, overflow} !== 6'b000000) begin
      n_fail++; $display("FAIL arst_immediate pend/insvc/ovf got=%b exp=000000", {pending, in_service, overflow});
    end
    tick();
    tick();
    rstn = 1'b1;
    repeat (8) tick();
    n_checks++;
    if ({pending, in_service} !== 4'b0000) begin
      n_fail++; $display("FAIL arst_count_cleared pend/insvc got=%b exp=0000", {pending, in_service});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_level();
    test_level_repend();
    test_edge_count();
    test_saturation();
    test_illegal_ids();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
